// File: rtl/prepaid_supply_ctrl.sv
// prepaid_supply_ctrl: relay sequencing (ON/LOW/GRACE/CUT) plus recharge req/ack/rej arbitration with credit-load strobe.
// Optional grace period enabled by defining GRACE_PERIOD_EN.
module prepaid_supply_ctrl #(
  parameter int BAL_W      = 10,
  parameter int LOW_THRESH = 50,
  parameter int GRACE_DAYS = 2,
  parameter int MAX_BAL    = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             date_1,
  input  logic [BAL_W-1:0] balance,
  input  logic             rch_req,
  input  logic [BAL_W-1:0] rch_amt,
  output logic             rch_ack,
  output logic             rch_rej,
  output logic [BAL_W-1:0] load_val,
  output logic             load_stb,
  output logic             relay_on,
  output logic             alert_low,
  output logic             alert_grace,
  output logic [2:0]       state,
  output logic [3:0]       grace_left
);
  localparam logic [2:0] S_ON = 3'd0, S_LOW = 3'd1, S_GRACE = 3'd2, S_CUT = 3'd3, S_LOAD = 3'd4;
  localparam logic [BAL_W-1:0] LOW_V = BAL_W'(LOW_THRESH);
  localparam logic [BAL_W:0] MAX_V = (BAL_W+1)'(MAX_BAL);
  localparam logic [3:0] GRACE_V = 4'(GRACE_DAYS);
  logic [1:0] r_sync;
  logic r_date_d, r_day, r_out, r_relay, r_ack, r_rej, r_stb;
  logic [2:0] r_state;
  logic [3:0] r_grace;
  logic [BAL_W-1:0] r_load_val;
  logic [BAL_W:0] w_sum;
  logic w_zero, w_hi, w_req, w_bad;
  logic [2:0] w_empty, w_eval, w_norm, w_next;
  logic [3:0] w_grace_n;
  assign w_sum  = {1'b0, balance} + {1'b0, rch_amt};
  assign w_zero = balance == '0;
  assign w_hi   = balance > LOW_V;
  assign w_req  = rch_req & ~r_out & (r_state != S_LOAD);
  assign w_bad  = (rch_amt == '0) || (w_sum > MAX_V);
  assign w_eval = w_hi ? S_ON : (w_zero ? S_CUT : S_LOW);
  assign w_norm = w_zero ? w_empty : (w_hi ? S_ON : S_LOW);
`ifdef GRACE_PERIOD_EN
  assign w_empty = S_GRACE;
`else
  assign w_empty = S_CUT;
`endif
  // A pending request always wins over balance re-evaluation and day ticks
  always_comb begin
    w_next = w_req ? (w_bad ? r_state : S_LOAD) :
             (r_state == S_LOAD)  ? S_CUT :
             (r_state == S_CUT)   ? w_eval :
             (r_state == S_GRACE) ? (!w_zero ? w_eval : ((r_day && r_grace == 4'd1) ? S_CUT : S_GRACE)) :
             w_norm;
`ifdef GRACE_PERIOD_EN
    w_grace_n = (w_next != S_GRACE) ? 4'd0 :
                (r_state != S_GRACE) ? GRACE_V :
                (r_day && !w_req) ? r_grace - 4'd1 : r_grace;
`else
    w_grace_n = 4'd0;
`endif
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync     <= '0;
      r_date_d   <= 1'b0;
      r_day      <= 1'b0;
      r_out      <= 1'b0;
      r_state    <= S_CUT;
      r_relay    <= 1'b0;
      r_ack      <= 1'b0;
      r_rej      <= 1'b0;
      r_stb      <= 1'b0;
      r_load_val <= '0;
      r_grace    <= '0;
    end else begin
      r_sync     <= {r_sync[0], date_1};
      r_date_d   <= r_sync[1];
      r_day      <= r_sync[1] & ~r_date_d;
      r_out      <= rch_req & (r_out | w_req);
      r_state    <= w_next;
      r_relay    <= (w_next == S_CUT) ? 1'b0 : ((w_next == S_LOAD) ? r_relay : 1'b1);
      r_ack      <= r_state == S_LOAD;
      r_rej      <= w_req & w_bad;
      r_stb      <= w_req & ~w_bad;
      r_load_val <= (w_req & ~w_bad) ? rch_amt : '0;
      r_grace    <= w_grace_n;
    end
  end
  assign rch_ack     = r_ack;
  assign rch_rej     = r_rej;
  assign load_val    = r_load_val;
  assign load_stb    = r_stb;
  assign relay_on    = r_relay;
  assign alert_low   = r_state == S_LOW;
  assign alert_grace = r_state == S_GRACE;
  assign state       = r_state;
  assign grace_left  = r_grace;
endmodule
